// File: rtl/window_3x3_gen.sv
// Raster-to-window generator: two line buffers plus column shift registers
// present a registered 3x3 neighbourhood for each interior pixel of a frame.
module window_3x3_gen #(
    parameter int width = 8,
    parameter int img_w = 640,
    parameter int img_h = 480,
    parameter int cnt_w = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             in_sof,
    input  logic [width-1:0] in_data,
    output logic             out_valid,
    output logic [width-1:0] p11,
    output logic [width-1:0] p12,
    output logic [width-1:0] p13,
    output logic [width-1:0] p21,
    output logic [width-1:0] p22,
    output logic [width-1:0] p23,
    output logic [width-1:0] p31,
    output logic [width-1:0] p32,
    output logic [width-1:0] p33,
    output logic [cnt_w-1:0] out_row,
    output logic [cnt_w-1:0] out_col,
    output logic             out_eof
);

    localparam int aw = (img_w > 1) ? $clog2(img_w) : 1;
    localparam logic [cnt_w-1:0] col_last = cnt_w'(img_w - 1);
    localparam logic [cnt_w-1:0] row_last = cnt_w'(img_h - 1);
    localparam logic [cnt_w-1:0] two      = cnt_w'(2);

    logic [width-1:0] lb1 [0:img_w-1];
    logic [width-1:0] lb2 [0:img_w-1];

    logic [cnt_w-1:0] col, row;
    logic [cnt_w-1:0] pc, pr;
    logic [aw-1:0]    pi;
    logic             accept, win;
    logic [width-1:0] rd1, rd2;

    // Column history: *1 holds column c-1, *2 holds column c-2.
    logic [width-1:0] top1, top2, mid1, mid2, bot1, bot2;

    always_comb begin
        accept = in_valid & ~rst;
        pc     = in_sof ? '0 : col;
        pr     = in_sof ? '0 : row;
        pi     = pc[aw-1:0];
        rd1    = lb1[pi];
        rd2    = lb2[pi];
        win    = accept && (pr >= two) && (pc >= two);
    end

    // Read-before-write: lb2 takes the value lb1 held before this accept.
    always_ff @(posedge clk) begin
        if (accept) begin
            lb1[pi] <= in_data;
            lb2[pi] <= rd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col       <= '0;
            row       <= '0;
            top1      <= '0;
            top2      <= '0;
            mid1      <= '0;
            mid2      <= '0;
            bot1      <= '0;
            bot2      <= '0;
            out_valid <= 1'b0;
            out_eof   <= 1'b0;
            p11       <= '0;
            p12       <= '0;
            p13       <= '0;
            p21       <= '0;
            p22       <= '0;
            p23       <= '0;
            p31       <= '0;
            p32       <= '0;
            p33       <= '0;
            out_row   <= '0;
            out_col   <= '0;
        end else begin
            out_valid <= win;
            out_eof   <= win && (pr == row_last) && (pc == col_last);
            if (accept) begin
                if (pc == col_last) begin
                    col <= '0;
                    row <= (pr == row_last) ? '0 : pr + 1'b1;
                end else begin
                    col <= pc + 1'b1;
                    row <= pr;
                end
                top2 <= top1;
                top1 <= rd2;
                mid2 <= mid1;
                mid1 <= rd1;
                bot2 <= bot1;
                bot1 <= in_data;
            end
            if (win) begin
                p11     <= top2;
                p12     <= top1;
                p13     <= rd2;
                p21     <= mid2;
                p22     <= mid1;
                p23     <= rd1;
                p31     <= bot2;
                p32     <= bot1;
                p33     <= in_data;
                out_row <= pr - 1'b1;
                out_col <= pc - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_window_3x3_gen.sv
// Randomized bench for window_3x3_gen: every cycle the outputs are compared
// against a frame-image reference model.
module tb_window_3x3_gen;

    localparam int W  = 5;
    localparam int H  = 4;
    localparam int CW = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_sof;
    logic [7:0]    in_data;
    logic          out_valid;
    logic [7:0]    p11, p12, p13, p21, p22, p23, p31, p32, p33;
    logic [CW-1:0] out_row, out_col;
    logic          out_eof;

    window_3x3_gen #(.width(8), .img_w(W), .img_h(H), .cnt_w(CW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof), .in_data(in_data),
        .out_valid(out_valid),
        .p11(p11), .p12(p12), .p13(p13), .p21(p21), .p22(p22), .p23(p23),
        .p31(p31), .p32(p32), .p33(p33),
        .out_row(out_row), .out_col(out_col), .out_eof(out_eof)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: the current frame as an image, plus position in raster order.
    logic [7:0] img [0:H-1][0:W-1];
    int         m_n;
    logic       e_valid, e_eof;
    logic [7:0] e_p [0:8];
    int         e_row, e_col;
    int         win_seen;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_n = 0;
        e_valid = 1'b0;
        e_eof = 1'b0;
        for (int i = 0; i < 9; i++) e_p[i] = 8'h00;
        e_row = 0;
        e_col = 0;
    endtask

    task automatic model_step(input logic v, input logic sof, input logic [7:0] d, input logic r);
        int pr, pc;
        e_valid = 1'b0;
        e_eof = 1'b0;
        if (r) begin
            model_reset();
        end else if (v) begin
            if (sof) m_n = 0;
            pr = m_n / W;
            pc = m_n % W;
            img[pr][pc] = d;
            if (pr >= 2 && pc >= 2) begin
                e_valid = 1'b1;
                for (int i = 0; i < 3; i++)
                    for (int j = 0; j < 3; j++)
                        e_p[i*3+j] = img[pr-2+i][pc-2+j];
                e_row = pr - 1;
                e_col = pc - 1;
                e_eof = (pr == H-1) && (pc == W-1);
            end
            m_n = (m_n + 1) % (W*H);
        end
    endtask

    task automatic drive(input logic v, input logic sof, input logic [7:0] d, input logic r);
        rst = r;
        in_valid = v;
        in_sof = sof;
        in_data = d;
        @(posedge clk);
        model_step(v, sof, d, r);
        #1;
        check("out_valid", {31'b0, out_valid}, {31'b0, e_valid});
        check("out_eof", {31'b0, out_eof}, {31'b0, e_eof});
        check("p11", {24'b0, p11}, {24'b0, e_p[0]});
        check("p12", {24'b0, p12}, {24'b0, e_p[1]});
        check("p13", {24'b0, p13}, {24'b0, e_p[2]});
        check("p21", {24'b0, p21}, {24'b0, e_p[3]});
        check("p22", {24'b0, p22}, {24'b0, e_p[4]});
        check("p23", {24'b0, p23}, {24'b0, e_p[5]});
        check("p31", {24'b0, p31}, {24'b0, e_p[6]});
        check("p32", {24'b0, p32}, {24'b0, e_p[7]});
        check("p33", {24'b0, p33}, {24'b0, e_p[8]});
        check("out_row", {22'b0, out_row}, e_row);
        check("out_col", {22'b0, out_col}, e_col);
        if (out_valid === 1'b1) win_seen++;
    endtask

    function automatic logic [7:0] pix(input int r, input int c, input int mode);
        logic [7:0] v;
        case (mode)
            0: v = {r[3:0], c[3:0]};
            1: v = {r[3:0], c[3:0]} ^ 8'h80;
            2: v = (r == 2 && c == 2) ? 8'h00 : 8'hFF;
            default: v = 8'($urandom);
        endcase
        return v;
    endfunction

    task automatic idle();
        drive(1'b0, 1'($urandom), 8'($urandom), 1'b0);
    endtask

    // Sends cnt pixels starting at raster index n0; bub is the idle percentage.
    task automatic send(input int n0, input int cnt, input int mode, input int bub, input logic sof_first);
        int p;
        for (int i = 0; i < cnt; i++) begin
            while ($urandom_range(99) < bub) idle();
            p = (n0 + i) % (W*H);
            drive(1'b1, sof_first && (i == 0), pix(p / W, p % W, mode), 1'b0);
        end
    endtask

    initial begin
        model_reset();
        win_seen = 0;
        drive(1'b0, 1'b0, 8'h00, 1'b1);
        drive(1'b1, 1'b1, 8'h5A, 1'b1);     // rst wins over a simultaneous accept

        // Basic frame at full rate.
        win_seen = 0;
        send(0, W*H, 0, 0, 1'b0);
        idle();
        check("basic_windows", win_seen, 6);

        // Same frame with random bubbles.
        win_seen = 0;
        send(0, W*H, 0, 40, 1'b0);
        idle();
        check("bubble_windows", win_seen, 6);

        // Two frames back-to-back without in_sof.
        win_seen = 0;
        send(0, 2*W*H, 0, 0, 1'b0);
        idle();
        check("b2b_windows", win_seen, 12);

        // Abort after 8 pixels with a new frame starting on in_sof.
        win_seen = 0;
        send(0, 8, 0, 20, 1'b0);
        send(0, W*H, 1, 20, 1'b1);
        idle();
        check("sof_windows", win_seen, 6);

        // Reset mid-frame, then a fresh frame.
        send(0, 12, 3, 0, 1'b0);
        drive(1'b1, 1'b0, 8'hEE, 1'b1);
        idle();
        win_seen = 0;
        send(0, W*H, 0, 30, 1'b0);
        idle();
        check("post_rst_windows", win_seen, 6);

        // in_sof exactly where the counters wrap anyway.
        send(0, W*H, 3, 0, 1'b0);
        win_seen = 0;
        send(0, W*H, 3, 30, 1'b1);
        idle();
        check("sof_at_wrap_windows", win_seen, 6);

        // Corner values and random frames.
        win_seen = 0;
        send(0, W*H, 2, 0, 1'b0);
        idle();
        check("corner_windows", win_seen, 6);
        for (int k = 0; k < 4; k++) send(0, W*H, 3, 35, 1'b0);
        repeat (3) idle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/window_3x3_gen.md
# window_3x3_gen

Raster-to-window generator that feeds the 3x3 median filter. Accepts one pixel per clock (with bubbles) in row-major order, keeps the two previous image lines in internal line buffers, and presents a registered 3x3 neighbourhood (p11..p33) with a valid strobe. Its outputs connect directly to the nine window inputs of the combinational median stage.

## Interface

Parameters:
- width, 8, bits per pixel
- img_w, 640, pixels per line (≥3)
- img_h, 480, lines per frame (≥3)
- cnt_w, 10, counter width; must hold img_w-1 and img_h-1

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  in_data accepted this cycle; there is no backpressure
- in_sof  in  1  qualified by in_valid: the accepted pixel is (row 0, col 0)
- in_data  in  width  pixel value
- out_valid  out  1  window outputs valid this cycle
- p11,p12,p13  out  width  top row of the window (oldest line), left to right
- p21,p22,p23  out  width  middle row of the window
- p31,p32,p33  out  width  bottom row of the window (newest line)
- out_row  out  cnt_w  row of the window centre (p22)
- out_col  out  cnt_w  column of the window centre (p22)
- out_eof  out  1  with out_valid: last window of the frame

## Operation

- Counters `col` (0..img_w-1) and `row` (0..img_h-1) give the position of the next accepted pixel.
- On each accept, `col` increments. At img_w-1 it wraps to 0 and `row` increments. At (img_h-1, img_w-1) both wrap to 0, so back-to-back frames work without in_sof.
- in_sof & in_valid: the pixel is placed at (0,0), and the counters become (0,1) regardless of their prior state. This aborts any partial frame. in_sof without in_valid is ignored.
- Line buffers: lb1 holds line r-1 and lb2 holds line r-2. Each is img_w entries, indexed by col.
- On accept at col c: read lb1[c] and lb2[c] (old contents), write lb1[c] ← in_data and lb2[c] ← old lb1[c]. Read-before-write semantics are required.
- Three 3-stage column shift registers (top = lb2 data, mid = lb1 data, bottom = in_data) shift only on accept.
- A window is emitted for an accepted pixel at (r,c) only when r ≥ 2 and c ≥ 2:
  - p1x = line r-2, cols c-2, c-1, c
  - p2x = line r-1, cols c-2, c-1, c
  - p3x = line r, cols c-2, c-1, c
  - out_row = r-1, out_col = c-1
- Border pixels produce no window: no padding and no replication. Output count per frame is exactly (img_w-2)(img_h-2).
- out_eof = 1 on the window produced by pixel (img_h-1, img_w-1).
- Stale shift-register or line-buffer data at cols 0–1, rows 0–1, or after in_sof is never exposed, because outputs are gated by the r/c ≥ 2 condition.
- Line buffers are not cleared by rst or in_sof.

## Timing

- Latency: window outputs and out_valid are registered, 1 cycle after the accepting edge of the completing pixel.
- Throughput: 1 window per cycle at full input rate. Bubbles on in_valid produce matching bubbles on out_valid.
- When out_valid = 0, p11..p33, out_row and out_col hold their last values. out_eof is 0.
- Reset values: out_valid = 0, out_eof = 0, p11..p33 = 0, out_row = 0, out_col = 0, col = 0, row = 0, shift registers = 0.
- rst mid-frame: the next cycle behaves as idle after reset, and the next accepted pixel is (0,0).
- rst and in_valid in the same cycle: rst wins and the pixel is dropped.
- in_sof at the cycle where counters would wrap anyway: result is identical, pixel at (0,0).

## Test plan

Bench parameters: img_w=5, img_h=4, width=8. Pixel value = {row[3:0], col[3:0]}.

- **Basic frame, in_valid held high:** first out_valid one cycle after pixel 0x22 with p11..p13=00,01,02, p21..p23=10,11,12, p31..p33=20,21,22, out_row=1, out_col=1. Exactly 6 windows per frame. Last window centre (2,3) has p33=0x34 and out_eof=1.
- **Random in_valid bubbles (~40%):** identical window sequence to the basic frame. Each out_valid comes exactly 1 cycle after its completing accept, and no out_valid appears otherwise.
- **Two frames back-to-back, no in_sof:** 12 windows. The second frame's first window again has p11=0x00, p33=0x22 and out_row/out_col=1/1.
- **in_sof mid-frame:** after 8 pixels, assert in_sof with a new frame. No out_valid until that frame's pixel (2,2). Its windows contain only new-frame data.
- **rst mid-frame after 12 pixels:** all outputs 0 next cycle. A fresh frame then yields exactly 6 correct windows.
- **Corner values:** frame of all 0xFF except centre 0x00. Every window's p-values match the golden model, and no byte is corrupted at line wrap.
